// File: rtl/booth_digit_sequencer.sv
// Booth multiplier-operand sequencer: emits overlapping (D+1)-bit windows LSB first, one per digit handshake.
// Latency: first window 1 cycle after load; while digit_ready=0 the window, index and last flag hold.
module booth_digit_sequencer #(
  parameter int WIDTH      = 16,
  parameter int DIGIT_BITS = 4,
  parameter int EARLY_TERM = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_data,
  input  logic                  load_signed,
  output logic                  digit_valid,
  input  logic                  digit_ready,
  output logic [DIGIT_BITS:0]   digit,
  output logic [((((WIDTH+DIGIT_BITS)/DIGIT_BITS) > 1) ? $clog2((WIDTH+DIGIT_BITS)/DIGIT_BITS) : 1)-1:0] digit_idx,
  output logic                  digit_last,
  output logic                  busy
);

  localparam int D    = DIGIT_BITS;
  localparam int NDIG = (WIDTH + D) / D;
  localparam int EXT  = NDIG * D;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [EXT-1:0]  sr_q, sr_d;
  logic            pb_q, pb_d;
  logic            fb_q, fb_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [EXT-1:0]  sr_shifted;
  logic            upper_match;
  logic            in_shift;
  logic            is_last;
  logic            load_fire;
  logic            dig_fire;
  logic            load_fill;

  // upper_match: every bit above the current digit copies its MSB, so all later Booth digits are zero
  generate
    if (NDIG > 1) begin : g_multi
      assign sr_shifted  = {{D{fb_q}}, sr_q[EXT-1:D]};
      assign upper_match = (sr_q[EXT-1:D] == {(EXT-D){sr_q[D-1]}});
    end else begin : g_single
      assign sr_shifted  = {D{fb_q}};
      assign upper_match = 1'b1;
    end
  endgenerate

  assign in_shift  = (state_q == ST_SHIFT);
  assign is_last   = in_shift & ((idx_q == LAST_IDX) | ((EARLY_TERM != 0) & upper_match));
  assign load_fire = load_valid & ~in_shift & ~flush;
  assign dig_fire  = in_shift & digit_ready & ~flush;
  assign load_fill = load_signed & load_data[WIDTH-1];

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pb_d    = pb_q;
    fb_d    = fb_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (load_fire) begin
      sr_d    = {{(EXT-WIDTH){load_fill}}, load_data};
      fb_d    = load_fill;
      pb_d    = 1'b0;
      idx_d   = '0;
      state_d = ST_SHIFT;
    end else if (dig_fire) begin
      if (is_last) begin
        state_d = ST_IDLE;
      end else begin
        sr_d  = sr_shifted;
        pb_d  = sr_q[D-1];
        idx_d = idx_q + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      pb_q    <= 1'b0;
      fb_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pb_q    <= pb_d;
      fb_q    <= fb_d;
      idx_q   <= idx_d;
    end
  end

  assign load_ready  = ~in_shift;
  assign digit_valid = in_shift;
  assign busy        = in_shift;
  assign digit       = in_shift ? {sr_q[D-1:0], pb_q} : '0;
  assign digit_idx   = in_shift ? idx_q : '0;
  assign digit_last  = is_last;

endmodule

// File: tb/tb_booth_digit_sequencer.sv
// Directed bench for booth_digit_sequencer: two instances (no early termination / early termination) share stimulus.
module tb_booth_digit_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_signed = 1'b0;
  logic        digit_ready = 1'b1;

  logic       load_ready0, digit_valid0, digit_last0, busy0;
  logic [4:0] digit0;
  logic [2:0] digit_idx0;
  logic       load_ready1, digit_valid1, digit_last1, busy1;
  logic [4:0] digit1;
  logic [2:0] digit_idx1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  booth_digit_sequencer #(.WIDTH(16), .DIGIT_BITS(4), .EARLY_TERM(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .load_valid(load_valid), .load_ready(load_ready0), .load_data(load_data), .load_signed(load_signed),
    .digit_valid(digit_valid0), .digit_ready(digit_ready), .digit(digit0), .digit_idx(digit_idx0),
    .digit_last(digit_last0), .busy(busy0)
  );

  booth_digit_sequencer #(.WIDTH(16), .DIGIT_BITS(4), .EARLY_TERM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .load_valid(load_valid), .load_ready(load_ready1), .load_data(load_data), .load_signed(load_signed),
    .digit_valid(digit_valid1), .digit_ready(digit_ready), .digit(digit1), .digit_idx(digit_idx1),
    .digit_last(digit_last1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    digit_ready = 1'b1;
    for (int i = 0; i < 20 && !(load_ready0 && load_ready1); i++) step();
    check("idle_wait", {31'b0, load_ready0 & load_ready1}, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic s);
    wait_idle();
    load_valid  = 1'b1;
    load_data   = d;
    load_signed = s;
    step();
    load_valid  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lrdy"}, {31'b0, load_ready0}, 32'd1);
    check({tag, "_vld"},  {31'b0, digit_valid0}, 32'd0);
    check({tag, "_dig"},  {27'b0, digit0}, 32'd0);
    check({tag, "_idx"},  {29'b0, digit_idx0}, 32'd0);
    check({tag, "_last"}, {31'b0, digit_last0}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy0}, 32'd0);
    check({tag, "_vld1"}, {31'b0, digit_valid1}, 32'd0);
  endtask

  function automatic int booth(input logic [4:0] w);
    int v = 0;
    if (w[4]) v -= 8;
    if (w[3]) v += 4;
    if (w[2]) v += 2;
    if (w[1]) v += 1;
    if (w[0]) v += 1;
    return v;
  endfunction

  logic [4:0] exp_1234 [5] = '{5'h08, 5'h06, 5'h04, 5'h02, 5'h00};
  logic [4:0] exp_8000 [5] = '{5'h00, 5'h00, 5'h00, 5'h10, 5'h1F};
  logic [4:0] exp_000f [2] = '{5'h1E, 5'h01};

  initial begin
    #1 rst_n = 1'b0;
    #6;
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;
    step();

    // Unsigned 0x1234, full digit count
    do_load(16'h1234, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("s1_dig%0d", i), {27'b0, digit0}, {27'b0, exp_1234[i]});
      check($sformatf("s1_idx%0d", i), {29'b0, digit_idx0}, i);
      check($sformatf("s1_last%0d", i), {31'b0, digit_last0}, (i == 4) ? 32'd1 : 32'd0);
      step();
    end
    check("s1_lrdy_after", {31'b0, load_ready0}, 32'd1);

    // Signed 0x8000, with and without early termination
    do_load(16'h8000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("s2_dig%0d", i), {27'b0, digit0}, {27'b0, exp_8000[i]});
      check($sformatf("s2_last%0d", i), {31'b0, digit_last0}, (i == 4) ? 32'd1 : 32'd0);
      if (i < 4) begin
        check($sformatf("s2et_dig%0d", i), {27'b0, digit1}, {27'b0, exp_8000[i]});
        check($sformatf("s2et_last%0d", i), {31'b0, digit_last1}, (i == 3) ? 32'd1 : 32'd0);
      end else begin
        check("s2et_vld_after", {31'b0, digit_valid1}, 32'd0);
      end
      step();
    end

    // Unsigned 0x000F with early termination, reconstruct value
    begin
      int sum = 0;
      do_load(16'h000F, 1'b0);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("s3_dig%0d", i), {27'b0, digit1}, {27'b0, exp_000f[i]});
        check($sformatf("s3_last%0d", i), {31'b0, digit_last1}, (i == 1) ? 32'd1 : 32'd0);
        sum += booth(digit1) * (1 << (4 * i));
        step();
      end
      check("s3_sum", sum, 32'd15);
      check("s3_done", {31'b0, digit_valid1}, 32'd0);
    end

    // Backpressure at idx 2, load attempt ignored
    do_load(16'h1234, 1'b0);
    step();
    step();
    digit_ready = 1'b0;
    load_valid  = 1'b1;
    load_data   = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("s4_dig%0d", i), {27'b0, digit0}, 32'h04);
      check($sformatf("s4_idx%0d", i), {29'b0, digit_idx0}, 32'd2);
      check($sformatf("s4_lrdy%0d", i), {31'b0, load_ready0}, 32'd0);
    end
    load_valid  = 1'b0;
    digit_ready = 1'b1;
    step();
    check("s4_resume_dig", {27'b0, digit0}, 32'h02);
    check("s4_resume_idx", {29'b0, digit_idx0}, 32'd3);

    // Flush at idx 2 together with digit_ready
    do_load(16'h1234, 1'b0);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("s5_vld", {31'b0, digit_valid0}, 32'd0);
    check("s5_lrdy", {31'b0, load_ready0}, 32'd1);
    check("s5_idx", {29'b0, digit_idx0}, 32'd0);
    do_load(16'h0001, 1'b0);
    check("s5_new_dig", {27'b0, digit0}, 32'h02);
    check("s5_new_idx", {29'b0, digit_idx0}, 32'd0);

    // Asynchronous reset mid-sequence
    do_load(16'h1234, 1'b0);
    step();
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("s6_async");
    #2 rst_n = 1'b1;
    step();
    check("s6_no_digit", {31'b0, digit_valid0}, 32'd0);
    do_load(16'h1234, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("s6_dig%0d", i), {27'b0, digit0}, {27'b0, exp_1234[i]});
      check($sformatf("s6_idx%0d", i), {29'b0, digit_idx0}, i);
      step();
    end
    check("s6_lrdy_after", {31'b0, load_ready0}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
